// File: rtl/genesis_pad_scanner.sv
// Sega Genesis / Mega Drive controller scanner: drives the select line through
// 3- or 6-button read sequences and commits debounced-per-frame button state.
module genesis_pad_scanner #(
  parameter int NUM_PADS  = 2,
  parameter int PHASE_CYC = 500,
  parameter int IDLE_CYC  = 100000,
  parameter int SIX_BTN   = 1
) (
  input  logic                   sysclk,
  input  logic                   clr_n,
  input  logic                   en,
  input  logic [6*NUM_PADS-1:0]  pad_in,
  output logic [NUM_PADS-1:0]    pad_sel,
  output logic [12*NUM_PADS-1:0] buttons,
  output logic [12*NUM_PADS-1:0] pressed,
  output logic [NUM_PADS-1:0]    present,
  output logic [NUM_PADS-1:0]    six_btn,
  output logic                   frame_done,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(PHASE_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYC);
  localparam logic [2:0]    LAST_K    = (SIX_BTN != 0) ? 3'd7 : 3'd1;
  localparam logic [11:0]   BTN_MASK  = (SIX_BTN != 0) ? 12'hfff : 12'h0ff;

  logic [6*NUM_PADS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [PW-1:0]          ph_cnt_q, ph_cnt_d;
  logic [2:0]             k_q, k_d;
  logic [12*NUM_PADS-1:0] sh_btn_q, sh_btn_d;
  logic [NUM_PADS-1:0]    sh_pres_q, sh_pres_d, sh_six_q, sh_six_d;
  logic [12*NUM_PADS-1:0] btn_q, btn_d, prs_q, prs_d;
  logic [NUM_PADS-1:0]    pres_q, pres_d, six_q, six_d;
  logic                   sample;

  assign sample = (state_q == ST_SCAN) && (ph_cnt_q == PH_LAST);

  always_comb begin
    sync1_d    = pad_in;
    sync2_d    = sync1_q;
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    k_d        = k_q;
    sh_btn_d   = sh_btn_q;
    sh_pres_d  = sh_pres_q;
    sh_six_d   = sh_six_q;
    btn_d      = btn_q;
    prs_d      = '0;
    pres_d     = pres_q;
    six_d      = six_q;

    case (state_q)
      ST_IDLE: begin
        if (en && (idle_cnt_q >= IDLE_LAST)) begin
          state_d    = ST_SCAN;
          idle_cnt_d = '0;
          ph_cnt_d   = '0;
          k_d        = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (sample) begin
          ph_cnt_d = '0;
          if (k_q == LAST_K) state_d = ST_COMMIT;
          else               k_d     = k_q + 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d    = ST_IDLE;
        idle_cnt_d = '0;
        k_d        = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are active-low; each phase contributes its own slice of the shadow.
    if (sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        case (k_q)
          3'd0: begin
            sh_btn_d[12*p +: 12] = {5'b0, ~sync2_q[6*p+5], ~sync2_q[6*p+4], 1'b0,
                                    ~sync2_q[6*p+3], ~sync2_q[6*p+2],
                                    ~sync2_q[6*p+1], ~sync2_q[6*p]};
            sh_pres_d[p] = 1'b0;
            sh_six_d[p]  = 1'b0;
          end
          3'd1: begin
            sh_btn_d[12*p+4] = ~sync2_q[6*p+4];
            sh_btn_d[12*p+7] = ~sync2_q[6*p+5];
            sh_pres_d[p]     = ~sync2_q[6*p+2] & ~sync2_q[6*p+3];
          end
          3'd5: if (SIX_BTN != 0) sh_six_d[p] = ~|sync2_q[6*p +: 4];
          3'd6: if ((SIX_BTN != 0) && sh_six_q[p]) sh_btn_d[12*p+8 +: 4] = ~sync2_q[6*p +: 4];
          default: ;
        endcase
      end
    end

    // Commit from the next-shadow so the final phase's sample is included.
    if (sample && (k_q == LAST_K)) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        btn_d[12*p +: 12] = sh_pres_d[p] ? (sh_btn_d[12*p +: 12] & BTN_MASK) : 12'h000;
        six_d[p]          = (SIX_BTN != 0) ? (sh_pres_d[p] & sh_six_d[p]) : 1'b0;
      end
      pres_d = sh_pres_d;
      prs_d  = btn_d & ~btn_q;
    end
  end

  always_ff @(posedge sysclk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      ph_cnt_q   <= '0;
      k_q        <= '0;
      sh_btn_q   <= '0;
      sh_pres_q  <= '0;
      sh_six_q   <= '0;
      btn_q      <= '0;
      prs_q      <= '0;
      pres_q     <= '0;
      six_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      k_q        <= k_d;
      sh_btn_q   <= sh_btn_d;
      sh_pres_q  <= sh_pres_d;
      sh_six_q   <= sh_six_d;
      btn_q      <= btn_d;
      prs_q      <= prs_d;
      pres_q     <= pres_d;
      six_q      <= six_d;
    end
  end

  // Select idles high; during a scan it is low on odd phases only.
  assign pad_sel    = {NUM_PADS{(state_q != ST_SCAN) || !k_q[0]}};
  assign buttons    = btn_q;
  assign pressed    = prs_q;
  assign present    = pres_q;
  assign six_btn    = six_q;
  assign frame_done = (state_q == ST_COMMIT);
  assign state_dbg  = state_q;

endmodule
